// File: rtl/mux_n_pipe_if.sv
// Handshake/bus bundle for mux_n_pipe: N flattened input words plus select,
// upstream valid/ready, flush, and the registered output with its valid/ready.
interface mux_n_pipe_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4
);
    localparam int SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*WIDTH-1:0] DATA_IN;
    logic [SEL_W-1:0]        MUX_OP;
    logic                    IN_VALID;
    logic                    IN_READY;
    logic                    FLUSH;
    logic [WIDTH-1:0]        MUX_OUT;
    logic                    OUT_VALID;
    logic                    OUT_READY;
    logic                    SEL_ERR;

    modport master (
        output DATA_IN, MUX_OP, IN_VALID, FLUSH, OUT_READY,
        input  IN_READY, MUX_OUT, OUT_VALID, SEL_ERR
    );

    modport slave (
        input  DATA_IN, MUX_OP, IN_VALID, FLUSH, OUT_READY,
        output IN_READY, MUX_OUT, OUT_VALID, SEL_ERR
    );
endinterface

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input WIDTH-bit selector feeding a 2-entry skid buffer.
// MUX_OUT is always the main register, so there is no combinational path
// from DATA_IN/MUX_OP to the output, and IN_READY depends only on state and rst.
// Optional macro MUX_N_PIPE_SEL_CHECK_EN enables the sticky SEL_ERR flag for
// out-of-range selects; without it SEL_ERR is tied low.
module mux_n_pipe #(
    parameter int               WIDTH     = 32,
    parameter int               NUM_IN    = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic        clk,
    input  logic        rst,
    mux_n_pipe_if.slave bus
);
    localparam int SEL_W = $clog2(NUM_IN);

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] cap_d;
    logic             accept;

    // Select the addressed word; an unmatched (out-of-range) select yields zero.
    always_comb begin
        cap_d = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.MUX_OP == SEL_W'(k)) cap_d = bus.DATA_IN[k*WIDTH +: WIDTH];
        end
    end

    assign bus.IN_READY  = (state_q != FULL) && !rst;
    assign accept        = bus.IN_VALID && bus.IN_READY;
    assign bus.MUX_OUT   = main_q;
    assign bus.OUT_VALID = out_valid_q;

    // Skid-buffer FSM: main feeds the output, skid absorbs one beat of back-pressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VAL;
            skid_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (bus.FLUSH) begin
            state_q     <= EMPTY;
            main_q      <= RESET_VAL;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_q      <= cap_d;
                        out_valid_q <= 1'b1;
                        state_q     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && bus.OUT_READY) begin
                        main_q <= cap_d;
                    end else if (accept) begin
                        skid_q  <= cap_d;
                        state_q <= FULL;
                    end else if (bus.OUT_READY) begin
                        out_valid_q <= 1'b0;
                        state_q     <= EMPTY;
                    end
                end
                FULL: begin
                    if (bus.OUT_READY) begin
                        main_q  <= skid_q;
                        state_q <= ONE;
                    end
                end
                default: begin
                    state_q     <= EMPTY;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef MUX_N_PIPE_SEL_CHECK_EN
    logic sel_err_q;
    logic oor;

    assign oor = int'(bus.MUX_OP) >= NUM_IN;

    // Sticky out-of-range flag; only rst clears it, flush leaves it alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_err_q <= 1'b0;
        end else if (accept && oor) begin
            sel_err_q <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    // Simulation-only warning naming the offending select.
    always_ff @(posedge clk) begin
        if (!rst && accept && oor) begin
            $display("mux_n_pipe: warning, out-of-range MUX_OP=%0d", bus.MUX_OP);
        end
    end
`endif

    assign bus.SEL_ERR = sel_err_q;
`else
    assign bus.SEL_ERR = 1'b0;
`endif
endmodule
